// File: rtl/tdm_demux4_pkg.sv
// Shared definitions for the 4-slot TDM receive path.
package tdm_demux4_pkg;

  localparam int unsigned NUM_SLOTS = 4;
  localparam int unsigned SLOT_W    = 2;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_e;

endpackage

// File: rtl/tdm_demux4.sv
// 1:4 TDM demultiplexer: slot-aligned capture of a framed stream into four
// channel outputs, published atomically once per complete frame.
module tdm_demux4
  import tdm_demux4_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_sync,
  input  logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] w0,
  output logic [WIDTH-1:0] w1,
  output logic [WIDTH-1:0] w2,
  output logic [WIDTH-1:0] w3,
  output logic             out_valid,
  output logic             sync_err,
  output logic [CNT_W-1:0] frame_cnt
);

  state_e              state_q;
  logic [SLOT_W-1:0]   slot_q;
  logic [WIDTH-1:0]    sh0_q, sh1_q, sh2_q;
  logic [WIDTH-1:0]    w0_q, w1_q, w2_q, w3_q;
  logic                out_valid_q, sync_err_q;
  logic [CNT_W-1:0]    frame_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      slot_q      <= '0;
      sh0_q       <= '0;
      sh1_q       <= '0;
      sh2_q       <= '0;
      w0_q        <= '0;
      w1_q        <= '0;
      w2_q        <= '0;
      w3_q        <= '0;
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
      if (in_valid) begin
        unique case (state_q)
          HUNT: begin
            if (in_sync) begin
              sh0_q   <= f;
              slot_q  <= SLOT_W'(1);
              state_q <= LOCK;
            end
          end
          LOCK: begin
            if (in_sync) begin
              // An early sync aborts the partial frame and restarts at slot 0.
              if (slot_q != '0) sync_err_q <= 1'b1;
              sh0_q  <= f;
              slot_q <= SLOT_W'(1);
            end else begin
              unique case (slot_q)
                2'd0: begin
                  sync_err_q <= 1'b1;
                  state_q    <= HUNT;
                end
                2'd1: begin
                  sh1_q  <= f;
                  slot_q <= 2'd2;
                end
                2'd2: begin
                  sh2_q  <= f;
                  slot_q <= 2'd3;
                end
                default: begin
                  w0_q        <= sh0_q;
                  w1_q        <= sh1_q;
                  w2_q        <= sh2_q;
                  w3_q        <= f;
                  out_valid_q <= 1'b1;
                  frame_cnt_q <= frame_cnt_q + CNT_W'(1);
                  slot_q      <= '0;
                end
              endcase
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  assign w0        = w0_q;
  assign w1        = w1_q;
  assign w2        = w2_q;
  assign w3        = w3_q;
  assign out_valid = out_valid_q;
  assign sync_err  = sync_err_q;
  assign frame_cnt = frame_cnt_q;

endmodule
